// File: rtl/uart_hex_formatter.sv
// rtl/uart_hex_formatter.sv - formats a binary value as an ASCII hex line ("0x..." CR LF) for uart_tx
// One value per handshake; bytes leave through a registered valid/ready output stage.
module uart_hex_formatter #(
  parameter int NIBBLES   = 8,
  parameter bit PREFIX_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4*NIBBLES-1:0] value_in,
  input  logic                 value_valid,
  output logic                 value_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_data_valid,
  input  logic                 tx_data_ready,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PFX0,
    S_PFX1,
    S_DIGIT,
    S_CR,
    S_LF
  } state_e;

  state_e        state_q;
  logic [W-1:0]  shift_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;

  logic          accept;
  logic          xfer;
  logic [7:0]    shift_char_d;
  logic [7:0]    in_char_d;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h37 + {4'h0, n};
  endfunction

  assign accept = value_valid && (state_q == S_IDLE);
  assign xfer   = tx_valid_q && tx_data_ready;

  always_comb begin
    shift_char_d = hex_char(shift_q[W-1 -: 4]);
    in_char_d    = hex_char(value_in[W-1 -: 4]);
  end

  // state_q names the byte currently presented on tx_data; cnt_q holds digits still to follow it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            tx_valid_q <= 1'b1;
            if (PREFIX_EN) begin
              state_q   <= S_PFX0;
              tx_data_q <= 8'h30;
              shift_q   <= value_in;
            end else begin
              state_q   <= S_DIGIT;
              tx_data_q <= in_char_d;
              shift_q   <= value_in << 4;
              cnt_q     <= LAST_CNT;
            end
          end
        end
        S_PFX0: begin
          if (xfer) begin
            state_q   <= S_PFX1;
            tx_data_q <= 8'h78;
          end
        end
        S_PFX1: begin
          if (xfer) begin
            state_q   <= S_DIGIT;
            tx_data_q <= shift_char_d;
            shift_q   <= shift_q << 4;
            cnt_q     <= LAST_CNT;
          end
        end
        S_DIGIT: begin
          if (xfer) begin
            if (cnt_q == '0) begin
              state_q   <= S_CR;
              tx_data_q <= 8'h0D;
            end else begin
              tx_data_q <= shift_char_d;
              shift_q   <= shift_q << 4;
              cnt_q     <= cnt_q - 1'b1;
            end
          end
        end
        S_CR: begin
          if (xfer) begin
            state_q   <= S_LF;
            tx_data_q <= 8'h0A;
          end
        end
        S_LF: begin
          if (xfer) begin
            state_q    <= S_IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign value_ready   = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_valid_q;

endmodule

// File: tb/tb_uart_hex_formatter.sv
// tb/tb_uart_hex_formatter.sv - self-checking bench for uart_hex_formatter
// Two instances: 8 digits with prefix, and 4 digits without prefix.
module tb_uart_hex_formatter;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [31:0] value;
    int          mode;
    bit          scramble;
    logic [95:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [31:0] a_val_drv, a_junk, a_value_in;
  logic        a_scramble = 1'b0;
  logic        a_value_valid, a_value_ready, a_tx_valid, a_tx_ready, a_busy;
  logic [7:0]  a_tx_data;

  logic [15:0] b_value_in;
  logic        b_value_valid, b_value_ready, b_tx_valid, b_tx_ready, b_busy;
  logic [7:0]  b_tx_data;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  int   stretch = 0;
  bq_t  got, b_got, exp_q;
  int   got_cyc[$];
  int   b_got_cyc[$];
  logic a_prev_stall = 1'b0;
  logic [7:0] a_prev_data = 8'h00;
  vec_t vecs[4];

  assign a_value_in = a_scramble ? a_junk : a_val_drv;

  uart_hex_formatter u_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .value_in     (a_value_in),
    .value_valid  (a_value_valid),
    .value_ready  (a_value_ready),
    .tx_data      (a_tx_data),
    .tx_data_valid(a_tx_valid),
    .tx_data_ready(a_tx_ready),
    .busy         (a_busy)
  );

  uart_hex_formatter #(.NIBBLES(4), .PREFIX_EN(1'b0)) u_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .value_in     (b_value_in),
    .value_valid  (b_value_valid),
    .value_ready  (b_value_ready),
    .tx_data      (b_tx_data),
    .tx_data_valid(b_tx_valid),
    .tx_data_ready(b_tx_ready),
    .busy         (b_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Transfers are observed on the falling edge, where valid/ready equal their values at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      a_prev_stall = 1'b0;
    end else begin
      if (a_prev_stall) begin
        chk("stall_valid_held", a_tx_valid, 1);
        chk("stall_data_held", a_tx_data, a_prev_data);
      end
      if (a_tx_valid && a_tx_ready) begin
        got.push_back(a_tx_data);
        got_cyc.push_back(cyc);
      end
      if (b_tx_valid && b_tx_ready) begin
        b_got.push_back(b_tx_data);
        b_got_cyc.push_back(cyc);
      end
      a_prev_stall = a_tx_valid && !a_tx_ready;
      a_prev_data  = a_tx_data;
    end
  end

  initial begin
    a_tx_ready = 1'b1;
    a_junk     = '0;
    forever begin
      @(posedge clk);
      #1;
      a_junk = $urandom;
      if (rdy_mode == 0) begin
        a_tx_ready = 1'b1;
      end else if (stretch > 0) begin
        stretch--;
        a_tx_ready = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        stretch    = $urandom_range(1, 5);
        a_tx_ready = 1'b0;
      end else begin
        a_tx_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic build_exp(input logic [63:0] v, input int nib, input bit pfx);
    logic [3:0] n;
    exp_q.delete();
    if (pfx) begin
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h78);
    end
    for (int i = nib - 1; i >= 0; i--) begin
      n = 4'(v >> (4 * i));
      exp_q.push_back(n < 10 ? 8'(48 + n) : 8'(55 + n));
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic exp_from_vec(input logic [95:0] e, input int n);
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(e[8*(n-1-k) +: 8]);
  endtask

  task automatic cmp_bytes(input string nm, input bq_t act, input bq_t expq);
    chk({nm, "_len"}, act.size(), expq.size());
    for (int i = 0; i < expq.size() && i < act.size(); i++)
      chk($sformatf("%s_byte%0d", nm, i), act[i], expq[i]);
  endtask

  task automatic wait_a_ready(output bit found);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_value_ready) begin
        found = 1'b1;
        break;
      end
    end
    chk("accept_seen", found, 1);
  endtask

  task automatic wait_got(input int n);
    for (int i = 0; i < 3000 && got.size() < n; i++) begin
      @(negedge clk);
      #1;
    end
    chk("byte_count_reached", got.size() >= n, 1);
  endtask

  task automatic run_line(input logic [31:0] v, input int mode, input bit scr);
    bit found;
    got.delete();
    got_cyc.delete();
    rdy_mode = mode;
    @(posedge clk);
    #1;
    a_val_drv     = v;
    a_value_valid = 1'b1;
    wait_a_ready(found);
    @(posedge clk);
    #1;
    a_value_valid = 1'b0;
    a_scramble    = scr;
    chk("accept_latency_valid", a_tx_valid, 1);
    chk("accept_ready_low", a_value_ready, 0);
    chk("accept_busy_high", a_busy, 1);
    wait_got(12);
    @(negedge clk);
    chk("post_lf_ready", a_value_ready, 1);
    chk("post_lf_valid", a_tx_valid, 0);
    a_scramble = 1'b0;
    rdy_mode   = 0;
  endtask

  initial begin
    bit found;
    bq_t two;
    logic [31:0] rv;
    logic [15:0] bv;

    vecs[0] = '{32'hDEADBEEF, 0, 1'b0, 96'h3078_4445_4144_4245_4546_0D0A};
    vecs[1] = '{32'hDEADBEEF, 1, 1'b0, 96'h3078_4445_4144_4245_4546_0D0A};
    vecs[2] = '{32'h00000000, 0, 1'b1, 96'h3078_3030_3030_3030_3030_0D0A};
    vecs[3] = '{32'hFFFFFFFF, 1, 1'b1, 96'h3078_4646_4646_4646_4646_0D0A};

    rst_n         = 1'b0;
    a_val_drv     = '0;
    a_value_valid = 1'b0;
    b_value_in    = '0;
    b_value_valid = 1'b0;
    b_tx_ready    = 1'b1;
    #3;
    chk("rst_tx_data", a_tx_data, 8'h00);
    chk("rst_tx_valid", a_tx_valid, 0);
    chk("rst_value_ready", a_value_ready, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_b_tx_valid", b_tx_valid, 0);
    chk("rst_b_value_ready", b_value_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      run_line(vecs[v].value, vecs[v].mode, vecs[v].scramble);
      exp_from_vec(vecs[v].exp, 12);
      cmp_bytes($sformatf("vec%0d", v), got, exp_q);
      if (vecs[v].mode == 0 && got_cyc.size() == 12)
        chk($sformatf("vec%0d_zero_bubble", v), got_cyc[11] - got_cyc[0], 11);
    end

    for (int r = 0; r < 20; r++) begin
      rv = $urandom;
      run_line(rv, 1, 1'b1);
      build_exp(64'(rv), 8, 1'b1);
      cmp_bytes($sformatf("rand%0d", r), got, exp_q);
    end

    // value_valid held across two lines: second accept one idle cycle after the LF transfer
    got.delete();
    got_cyc.delete();
    rdy_mode = 0;
    @(posedge clk);
    #1;
    a_val_drv     = 32'h12345678;
    a_value_valid = 1'b1;
    wait_a_ready(found);
    @(posedge clk);
    #1;
    a_val_drv = 32'h9ABCDEF0;
    wait_got(12);
    @(negedge clk);
    chk("b2b_idle_ready", a_value_ready, 1);
    @(posedge clk);
    #1;
    a_value_valid = 1'b0;
    chk("b2b_second_accept", a_tx_valid, 1);
    wait_got(24);
    build_exp(64'h12345678, 8, 1'b1);
    two = exp_q;
    build_exp(64'h9ABCDEF0, 8, 1'b1);
    foreach (exp_q[i]) two.push_back(exp_q[i]);
    cmp_bytes("b2b", got, two);
    if (got_cyc.size() >= 13) chk("b2b_gap", got_cyc[12] - got_cyc[11], 2);
    @(negedge clk);

    // reset in the middle of a line, right after the 5th transfer
    got.delete();
    got_cyc.delete();
    @(posedge clk);
    #1;
    a_val_drv     = 32'hA5A5A5A5;
    a_value_valid = 1'b1;
    wait_a_ready(found);
    @(posedge clk);
    #1;
    a_value_valid = 1'b0;
    wait_got(5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_valid", a_tx_valid, 0);
    chk("midrst_value_ready", a_value_ready, 1);
    chk("midrst_busy", a_busy, 0);
    chk("midrst_tx_data", a_tx_data, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("midrst_no_more_bytes", got.size(), 5);
    chk("midrst_idle_valid", a_tx_valid, 0);

    // 4 digits, no prefix
    for (int r = 0; r < 6; r++) begin
      bv = (r == 0) ? 16'h1A2B : 16'($urandom);
      b_got.delete();
      b_got_cyc.delete();
      @(posedge clk);
      #1;
      b_value_in    = bv;
      b_value_valid = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (b_value_ready) begin
          found = 1'b1;
          break;
        end
      end
      chk("b_accept_seen", found, 1);
      @(posedge clk);
      #1;
      b_value_valid = 1'b0;
      b_value_in    = 16'h0000;
      chk("b_accept_latency", b_tx_valid, 1);
      for (int i = 0; i < 200 && b_got.size() < 6; i++) begin
        @(negedge clk);
        #1;
      end
      if (r == 0) exp_from_vec(96'h3141_3242_0D0A, 6);
      else build_exp(64'(bv), 4, 1'b0);
      cmp_bytes($sformatf("b_line%0d", r), b_got, exp_q);
      if (b_got_cyc.size() == 6) chk("b_zero_bubble", b_got_cyc[5] - b_got_cyc[0], 5);
      @(negedge clk);
      chk("b_post_lf_ready", b_value_ready, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
